// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: two-master round-robin AXI write arbiter onto one slave port.
// One AW/W/B transaction in flight; AW payload registered, W and B paths combinational.
module axi_wr_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [1:0]            m_awvalid,
    output logic [1:0]            m_awready,
    input  logic [2*ID_W-1:0]     m_awid,
    input  logic [2*ADDR_W-1:0]   m_awaddr,
    input  logic [31:0]           m_awlen,
    input  logic [1:0]            m_wvalid,
    output logic [1:0]            m_wready,
    input  logic [1:0]            m_wlast,
    input  logic [2*DATA_W-1:0]   m_wdata,
    output logic [1:0]            m_bvalid,
    input  logic [1:0]            m_bready,
    output logic [1:0]            m_bresp,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ID_W-1:0]       s_awid,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [7:0]            s_awlen,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic                  s_wlast,
    output logic [DATA_W-1:0]     s_wdata,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [1:0]            s_bresp,
    output logic                  len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t     state, state_nxt;
    logic       gnt, rr, sel;
    logic [1:0] gmask;
    logic [7:0] beats;
    logic       aw_hs, w_hs, b_hs;
    logic       unused_awlen_hi;
    assign unused_awlen_hi = ^{m_awlen[31:24], m_awlen[15:8]};
    // rr only breaks ties; a lone requester always wins
    assign sel     = (&m_awvalid) ? rr : m_awvalid[1];
    assign gmask   = gnt ? 2'b10 : 2'b01;
    assign s_wlast = gnt ? m_wlast[1] : m_wlast[0];
    assign s_wdata = gnt ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    assign m_bresp = s_bresp;
    always_comb begin
        state_nxt = state;
        s_awvalid = state == ADDR;
        m_awready = (state == ADDR && s_awready) ? gmask : 2'b00;
        s_wvalid  = state == DATA && (gnt ? m_wvalid[1] : m_wvalid[0]);
        m_wready  = (state == DATA && s_wready) ? gmask : 2'b00;
        s_bready  = state == RESP && (gnt ? m_bready[1] : m_bready[0]);
        m_bvalid  = (state == RESP && s_bvalid) ? gmask : 2'b00;
        aw_hs     = s_awvalid && s_awready;
        w_hs      = s_wvalid && s_wready;
        b_hs      = s_bready && s_bvalid;
        case (state)
            IDLE:    state_nxt = (|m_awvalid) ? ADDR : IDLE;
            ADDR:    state_nxt = aw_hs ? DATA : ADDR;
            DATA:    state_nxt = (w_hs && s_wlast) ? RESP : DATA;
            default: state_nxt = b_hs ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            rr       <= 1'b0;
            beats    <= 8'd0;
            len_err  <= 1'b0;
            s_awid   <= '0;
            s_awaddr <= '0;
            s_awlen  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |m_awvalid) begin
                gnt      <= sel;
                s_awid   <= sel ? m_awid[2*ID_W-1:ID_W] : m_awid[ID_W-1:0];
                s_awaddr <= sel ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
                s_awlen  <= sel ? m_awlen[23:16] : m_awlen[7:0];
            end
            if (aw_hs)
                beats <= 8'd0;
            // beats holds the zero-based index of the beat being accepted
            if (w_hs) begin
                beats <= beats + 8'd1;
                if ((s_wlast && beats != s_awlen) || (!s_wlast && beats == s_awlen))
                    len_err <= 1'b1;
            end
            if (b_hs)
                rr <= ~gnt;
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed scoreboard bench; expected AW/W/B events are queued in
// grant order and a monitor pops them against every handshake the DUT presents.
module tb_axi_wr_arbiter;
    localparam int TMO = 200;
    logic         aclk = 1'b0, aresetn = 1'b0;
    logic [1:0]   m_awvalid = '0, m_awready;
    logic [7:0]   m_awid = '0;
    logic [63:0]  m_awaddr = '0;
    logic [31:0]  m_awlen = '0;
    logic [1:0]   m_wvalid = '0, m_wready, m_wlast = '0;
    logic [63:0]  m_wdata = '0;
    logic [1:0]   m_bvalid, m_bready = '0, m_bresp;
    logic         s_awvalid, s_awready;
    logic [3:0]   s_awid;
    logic [31:0]  s_awaddr;
    logic [7:0]   s_awlen;
    logic         s_wvalid, s_wready, s_wlast;
    logic [31:0]  s_wdata;
    logic         s_bvalid, s_bready;
    logic [1:0]   s_bresp;
    logic         len_err;
    logic [53:0]  rst_view;
    typedef struct packed {logic [1:0] kind; logic [1:0] mask; logic [63:0] pay;} ev_t;
    ev_t          q[$];
    int           checks = 0, failures = 0, w_seen = 0;
    int           aw_dly = 0, b_dly = 0;
    logic [1:0]   b_resp = 2'b00;
    logic         pv = 1'b0, phs = 1'b0;
    logic [3:0]   pid = '0;
    logic [31:0]  paddr = '0;
    logic [7:0]   plen = '0;

    always #5 aclk = ~aclk;

    axi_wr_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .m_wdata(m_wdata), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
        .s_wdata(s_wdata), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .len_err(len_err)
    );

    assign rst_view = {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid,
                       len_err, s_awid, s_awaddr, s_awlen};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [31:0] dat(input int m, input logic [3:0] id, input int k);
        return 32'hD000_0000 | 32'(m << 16) | (32'(id) << 8) | 32'(k);
    endfunction

    task automatic exp_txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input int nb, input logic [1:0] resp);
        ev_t e;
        e.mask = (m == 1) ? 2'b10 : 2'b01;
        e.kind = 2'd0;
        e.pay  = 64'({id, addr, len});
        q.push_back(e);
        for (int k = 0; k < nb; k++) begin
            e.kind = 2'd1;
            e.pay  = 64'({dat(m, id, k), k == nb - 1});
            q.push_back(e);
        end
        e.kind = 2'd2;
        e.pay  = 64'(resp);
        q.push_back(e);
    endtask

    task automatic master_txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [15:0] len, input int nb);
        int t;
        m_awid[m*4 +: 4]    = id;
        m_awaddr[m*32 +: 32] = addr;
        m_awlen[m*16 +: 16]  = len;
        m_awvalid[m]         = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!m_awready[m] && aresetn && t < TMO);
        if (!aresetn || !m_awready[m]) begin
            if (aresetn) fail_now("aw_timeout");
            m_awvalid[m] = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        m_awvalid[m] = 1'b0;
        for (int k = 0; k < nb; k++) begin
            m_wdata[m*32 +: 32] = dat(m, id, k);
            m_wlast[m]  = (k == nb - 1);
            m_wvalid[m] = 1'b1;
            t = 0;
            do begin @(negedge aclk); t++; end while (!m_wready[m] && aresetn && t < TMO);
            if (!aresetn || !m_wready[m]) begin
                if (aresetn) fail_now("w_timeout");
                m_wvalid[m] = 1'b0;
                m_wlast[m]  = 1'b0;
                return;
            end
            @(posedge aclk); #1;
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        m_bready[m] = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!m_bvalid[m] && aresetn && t < TMO);
        if (aresetn && !m_bvalid[m]) fail_now("b_timeout");
        else if (aresetn) begin @(posedge aclk); #1; end
        m_bready[m] = 1'b0;
    endtask

    // slave: AW accepted after aw_dly+1 waiting cycles, B raised b_dly cycles after WLAST
    initial begin : slv
        int awc, bc;
        bit awhs, awp, wl, bhs, bpend;
        s_awready = 1'b0; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = 2'b00;
        awc = 0; bc = 0; bpend = 0;
        forever begin
            @(negedge aclk);
            awhs = s_awvalid && s_awready;
            awp  = s_awvalid;
            wl   = s_wvalid && s_wready && s_wlast;
            bhs  = s_bvalid && s_bready;
            @(posedge aclk); #1;
            s_bresp = b_resp;
            if (!aresetn) begin
                s_awready = 1'b0; s_bvalid = 1'b0; awc = 0; bc = 0; bpend = 0;
            end else begin
                if (awhs) begin s_awready = 1'b0; awc = 0; end
                else if (awp && !s_awready) begin
                    if (awc >= aw_dly) s_awready = 1'b1; else awc++;
                end
                if (wl) begin bpend = 1; bc = 0; end
                if (bhs) s_bvalid = 1'b0;
                else if (bpend) begin
                    if (bc >= b_dly) begin s_bvalid = 1'b1; bpend = 0; end else bc++;
                end
            end
        end
    end

    always @(negedge aclk) begin : mon
        ev_t  a;
        logic got;
        got = 1'b0;
        a   = '0;
        if (aresetn) begin
            if (s_awvalid && s_awready) begin
                got = 1'b1; a.kind = 2'd0; a.mask = m_awready; a.pay = 64'({s_awid, s_awaddr, s_awlen});
            end
            if (s_wvalid && s_wready) begin
                got = 1'b1; w_seen++; a.kind = 2'd1; a.mask = m_wready; a.pay = 64'({s_wdata, s_wlast});
            end
            if (|(m_bvalid & m_bready)) begin
                got = 1'b1; a.kind = 2'd2; a.mask = m_bvalid; a.pay = 64'(m_bresp);
            end
            if (got) begin
                if (q.size() == 0) fail_now("unexpected_event");
                else chk("event", 128'(a), 128'(q.pop_front()));
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (pv && !phs)
                chk("aw_hold", 128'({s_awvalid, s_awid, s_awaddr, s_awlen}), 128'({1'b1, pid, paddr, plen}));
            if (!(s_awvalid && s_awready))
                chk("awready_idle", 128'(m_awready), 128'(0));
        end
        pv    <= aresetn && s_awvalid;
        phs   <= s_awvalid && s_awready;
        pid   <= s_awid;
        paddr <= s_awaddr;
        plen  <= s_awlen;
    end

    initial begin
        #500000;
        fail_now("watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t;
        repeat (3) @(posedge aclk);
        #1 chk("reset_outs", 128'(rst_view), 128'(0));
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
        repeat (2) begin
            exp_txn(0, 4'd1, 32'h0000_0100, 8'd0, 1, 2'b00);
            exp_txn(1, 4'd2, 32'h0000_0200, 8'd2, 3, 2'b00);
            fork
                master_txn(0, 4'd1, 32'h0000_0100, 16'h0000, 1);
                master_txn(1, 4'd2, 32'h0000_0200, 16'hAB02, 3);
            join
        end
        aw_dly = 1;
        exp_txn(0, 4'd3, 32'h1000_0040, 8'd3, 4, 2'b00);
        master_txn(0, 4'd3, 32'h1000_0040, 16'h0003, 4);
        chk("len_err_ok", 128'(len_err), 128'(0));
        aw_dly = 0;
        b_resp = 2'b01;
        exp_txn(1, 4'd4, 32'h0000_0400, 8'd1, 2, 2'b01);
        exp_txn(0, 4'd5, 32'h0000_0500, 8'd0, 1, 2'b01);
        fork
            master_txn(0, 4'd5, 32'h0000_0500, 16'h5500, 1);
            master_txn(1, 4'd4, 32'h0000_0400, 16'h0001, 2);
        join
        aw_dly = 4;
        b_resp = 2'b10;
        exp_txn(1, 4'd9, 32'hCAFE_0000, 8'd1, 2, 2'b10);
        master_txn(1, 4'd9, 32'hCAFE_0000, 16'h0001, 2);
        aw_dly = 0;
        b_dly  = 9;
        b_resp = 2'b01;
        exp_txn(0, 4'd6, 32'h0000_0600, 8'd2, 3, 2'b01);
        exp_txn(1, 4'd7, 32'h0000_0700, 8'd0, 1, 2'b01);
        fork
            master_txn(0, 4'd6, 32'h0000_0600, 16'h0002, 3);
            begin
                repeat (3) @(posedge aclk);
                #1 master_txn(1, 4'd7, 32'h0000_0700, 16'h0000, 1);
            end
        join
        b_dly  = 0;
        b_resp = 2'b00;
        exp_txn(0, 4'd10, 32'h0000_0800, 8'd1, 1, 2'b00);
        master_txn(0, 4'd10, 32'h0000_0800, 16'h0001, 1);
        chk("len_err_set", 128'(len_err), 128'(1));
        exp_txn(0, 4'd11, 32'h0000_0900, 8'd0, 1, 2'b00);
        master_txn(0, 4'd11, 32'h0000_0900, 16'h0000, 1);
        chk("len_err_sticky", 128'(len_err), 128'(1));
        exp_txn(0, 4'd12, 32'h0000_0A00, 8'd3, 4, 2'b00);
        w_seen = 0;
        fork
            master_txn(0, 4'd12, 32'h0000_0A00, 16'h0003, 4);
        join_none
        t = 0;
        do begin @(posedge aclk); t++; end while (w_seen < 2 && t < TMO);
        if (w_seen < 2) fail_now("beat2_timeout");
        #2 aresetn = 1'b0;
        #1 chk("reset_mid", 128'(rst_view), 128'(0));
        q.delete();
        repeat (3) @(posedge aclk);
        #1 chk("reset_held", 128'(rst_view), 128'(0));
        @(negedge aclk) aresetn = 1'b1;
        @(posedge aclk); #1;
        exp_txn(0, 4'd13, 32'h0000_0B00, 8'd2, 3, 2'b00);
        exp_txn(1, 4'd14, 32'h0000_0C00, 8'd0, 2, 2'b00);
        fork
            master_txn(0, 4'd13, 32'h0000_0B00, 16'h0002, 3);
            master_txn(1, 4'd14, 32'h0000_0C00, 16'h0000, 2);
        join
        chk("len_err_early", 128'(len_err), 128'(1));
        repeat (2) @(posedge aclk);
        #1 chk("queue_empty", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
